// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) responder with 7-bit address match.
// Oversamples SCL/SDA on clk, detects START/STOP, receives write bytes on
// rx_data and serves read bytes from a valid/ready source over open-drain SDA.
// Optional build macro: I2C_TARGET_STRETCH_EN -- on a read byte load with no
// data available, hold SCL low until tx_valid instead of sending 8'hFF.
module i2c_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h27,
  parameter int         HOLD_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       busy,
  output logic       rw
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]          scl_sync_reg, sda_sync_reg;
  logic                scl_prev_reg, sda_prev_reg;
  logic [HOLD_CYC-1:0] fall_dly_reg;

  logic [7:0] shift_reg, shift_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic       flag_reg, flag_next;      // ACK phase started / initiator ACKed
  logic       sda_oe_reg, sda_oe_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       busy_reg, busy_next;
  logic       rw_reg, rw_next;
  logic       load_req;

  logic scl_rise, scl_fall, scl_hi, start_det, stop_det, drive_evt, sda_bit;
  logic [7:0] rx_byte;
  logic addr_hit;

  // Pins are asynchronous: two-stage synchronizer, then a previous copy for edges.
  // SDA-out timing runs off a delay line of SCL falling edges (data hold time).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_reg <= 2'b11;
      sda_sync_reg <= 2'b11;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
      fall_dly_reg <= '0;
    end else begin
      scl_sync_reg <= {scl_sync_reg[0], scl_in};
      sda_sync_reg <= {sda_sync_reg[0], sda_in};
      scl_prev_reg <= scl_sync_reg[1];
      sda_prev_reg <= sda_sync_reg[1];
      fall_dly_reg <= (fall_dly_reg << 1) | HOLD_CYC'(scl_fall);
    end
  end

  // START/STOP need SCL stable high across the sample pair, so a simultaneous
  // SCL+SDA change is only ever seen as an SCL edge.
  assign sda_bit   = sda_sync_reg[1];
  assign scl_rise  = scl_sync_reg[1] & ~scl_prev_reg;
  assign scl_fall  = ~scl_sync_reg[1] & scl_prev_reg;
  assign scl_hi    = scl_sync_reg[1] & scl_prev_reg;
  assign start_det = scl_hi & sda_prev_reg & ~sda_bit;
  assign stop_det  = scl_hi & ~sda_prev_reg & sda_bit;
  assign drive_evt = fall_dly_reg[HOLD_CYC-1];
  assign rx_byte   = {shift_reg[6:0], sda_bit};
  assign addr_hit  = (rx_byte[7:1] == SLAVE_ADDR);

`ifdef I2C_TARGET_STRETCH_EN
  logic scl_oe_reg, scl_oe_next;
  logic load_pend_reg, load_pend_next;

  // Stretch state: SCL held low while a read byte waits for tx_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_oe_reg    <= 1'b0;
      load_pend_reg <= 1'b0;
    end else begin
      scl_oe_reg    <= scl_oe_next;
      load_pend_reg <= load_pend_next;
    end
  end
  assign scl_oe = scl_oe_reg;
`else
  assign scl_oe = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; START and STOP override every state.
  always_comb begin
    state_next = state_reg;
    if (start_det) begin
      state_next = ADDR;
    end else if (stop_det) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        ADDR:     if (scl_rise && bit_cnt_reg == 4'd7) state_next = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (drive_evt && flag_reg) state_next = rw_reg ? RD_DATA : WR_DATA;
        WR_DATA:  if (scl_rise && bit_cnt_reg == 4'd7) state_next = WR_ACK;
        WR_ACK:   if (drive_evt && flag_reg) state_next = WR_DATA;
        RD_DATA:  if (drive_evt && bit_cnt_reg == 4'd8) state_next = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda_bit) state_next = WAIT_STOP;
          else if (drive_evt && flag_reg) state_next = RD_DATA;
        end
        default: ;
      endcase
    end
  end

  // Output/datapath logic: next values of registered outputs plus handshake pulses.
  always_comb begin
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    flag_next     = flag_reg;
    sda_oe_next   = sda_oe_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    busy_next     = busy_reg;
    rw_next       = rw_reg;
    tx_ready      = 1'b0;
    tx_underrun   = 1'b0;
    load_req      = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
    scl_oe_next    = scl_oe_reg;
    load_pend_next = load_pend_reg;
`endif
    if (start_det || stop_det) begin
      bit_cnt_next = 4'd0;
      flag_next    = 1'b0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
      scl_oe_next    = 1'b0;
      load_pend_next = 1'b0;
`endif
    end else begin
      case (state_reg)
        ADDR, WR_DATA: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              bit_cnt_next = 4'd0;
              flag_next    = 1'b0;
              if (state_reg == ADDR) begin
                if (addr_hit) begin
                  busy_next = 1'b1;
                  rw_next   = sda_bit;
                end
              end else begin
                rx_data_next  = rx_byte;
                rx_valid_next = 1'b1;
              end
            end
          end
        end
        ADDR_ACK, WR_ACK: begin
          // First delayed fall starts the ACK, the second ends it.
          if (drive_evt) begin
            if (!flag_reg) begin
              sda_oe_next = 1'b1;
              flag_next   = 1'b1;
            end else begin
              sda_oe_next = 1'b0;
              flag_next   = 1'b0;
              load_req    = (state_reg == ADDR_ACK) && rw_reg;
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (drive_evt) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = 4'd0;
              flag_next    = 1'b0;
            end else begin
              shift_next  = {shift_reg[6:0], 1'b1};
              sda_oe_next = ~shift_reg[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            flag_next = ~sda_bit;
          end else if (drive_evt && flag_reg) begin
            flag_next = 1'b0;
            load_req  = 1'b1;
          end
        end
        default: ;
      endcase
`ifdef I2C_TARGET_STRETCH_EN
      // No data yet: park with SCL held low; SCL is released the cycle after the handshake.
      if (load_req && !tx_valid) begin
        load_pend_next = 1'b1;
        scl_oe_next    = 1'b1;
        sda_oe_next    = 1'b0;
      end
      if ((load_req || load_pend_reg) && tx_valid) begin
        shift_next     = tx_data;
        sda_oe_next    = ~tx_data[7];
        tx_ready       = 1'b1;
        load_pend_next = 1'b0;
        scl_oe_next    = 1'b0;
      end
`else
      // No data available: send all-ones (SDA released) and flag the underrun.
      if (load_req) begin
        if (tx_valid) begin
          shift_next  = tx_data;
          sda_oe_next = ~tx_data[7];
          tx_ready    = 1'b1;
        end else begin
          shift_next  = 8'hFF;
          sda_oe_next = 1'b0;
          tx_underrun = 1'b1;
        end
      end
`endif
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg    <= 8'h00;
      bit_cnt_reg  <= 4'd0;
      flag_reg     <= 1'b0;
      sda_oe_reg   <= 1'b0;
      rx_data_reg  <= 8'h00;
      rx_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      rw_reg       <= 1'b0;
    end else begin
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      flag_reg     <= flag_next;
      sda_oe_reg   <= sda_oe_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      busy_reg     <= busy_next;
      rw_reg       <= rw_next;
    end
  end

  assign sda_oe   = sda_oe_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign busy     = busy_reg;
  assign rw       = rw_reg;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bus-initiator model driving i2c_target, with
// scoreboard queues for written bytes and read-back bytes.
module tb_i2c_target;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_in, sda_in, sda_oe, scl_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_underrun, busy, rw;

  int n_checks = 0;
  int n_fail = 0;
  int ready_cnt = 0;
  int underrun_cnt = 0;
  bit sda_oe_seen = 1'b0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] tx_q[$];

  // Open-drain wired-AND of initiator and target.
  assign scl_in = scl_m & ~scl_oe;
  assign sda_in = sda_m & ~sda_oe;

  i2c_target dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .busy(busy), .rw(rw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Written bytes: pop the scoreboard whenever the target reports one.
  always @(negedge clk) begin
    if (rx_valid) begin
      check("rx_pending", 32'(exp_rx.size() > 0), 32'd1);
      if (exp_rx.size() > 0) check("rx_data", rx_data, exp_rx.pop_front());
    end
    if (tx_underrun) underrun_cnt++;
    if (sda_oe) sda_oe_seen = 1'b1;
  end

  // tx source: advance after each handshake, drop valid when empty.
  always @(negedge clk) begin
    if (tx_ready && tx_valid) begin
      ready_cnt++;
      @(posedge clk);
      #1;
      if (tx_q.size() > 0) tx_data = tx_q.pop_front();
      else tx_valid = 1'b0;
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_in;   wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         rc0;
    int         ur0;
    bit         seen;

    repeat (4) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_rw", rw, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: write two bytes
    bus_start();
    write_byte(8'h4E, ack); check("t1_addr_ack", ack, 0);
    check("t1_busy", busy, 1);
    check("t1_rw", rw, 0);
    exp_rx.push_back(8'hA5);
    write_byte(8'hA5, ack); check("t1_ack1", ack, 0);
    exp_rx.push_back(8'h3C);
    write_byte(8'h3C, ack); check("t1_ack2", ack, 0);
    check("t1_busy_before_stop", busy, 1);
    bus_stop();
    check("t1_busy_after_stop", busy, 0);
    check("t1_rx_drained", exp_rx.size(), 0);

    // 2: read two bytes, ACK then NACK
    rc0 = ready_cnt;
    tx_data = 8'h81; tx_valid = 1'b1; tx_q.push_back(8'h7E);
    exp_rd.push_back(8'h81); exp_rd.push_back(8'h7E);
    bus_start();
    write_byte(8'h4F, ack); check("t2_addr_ack", ack, 0);
    check("t2_rw", rw, 1);
    read_byte(1'b0, d); check("t2_byte1", d, exp_rd.pop_front());
    read_byte(1'b1, d); check("t2_byte2", d, exp_rd.pop_front());
    wait_q();
    check("t2_sda_released", sda_oe, 0);
    check("t2_busy_wait_stop", busy, 1);
    check("t2_tx_ready_cnt", ready_cnt - rc0, 2);
    bus_stop();

    // 3: foreign address, target must stay silent
    sda_oe_seen = 1'b0;
    bus_start();
    write_byte(8'h50, ack); check("t3_addr_nack", ack, 1);
    write_byte(8'h12, ack); check("t3_data_nack1", ack, 1);
    write_byte(8'h34, ack); check("t3_data_nack2", ack, 1);
    seen = sda_oe_seen;
    check("t3_sda_never_driven", seen, 0);
    check("t3_busy", busy, 0);
    bus_stop();

    // 4: write then repeated START into a read
    bus_start();
    write_byte(8'h4E, ack); check("t4_addr_ack", ack, 0);
    exp_rx.push_back(8'h11);
    write_byte(8'h11, ack); check("t4_ack", ack, 0);
    check("t4_rx_data", rx_data, 8'h11);
    check("t4_rw_write", rw, 0);
    tx_data = 8'h5A; tx_valid = 1'b1;
    exp_rd.push_back(8'h5A);
    bus_start();
    write_byte(8'h4F, ack); check("t4_raddr_ack", ack, 0);
    check("t4_rw_read", rw, 1);
    read_byte(1'b1, d); check("t4_rd_byte", d, exp_rd.pop_front());
    bus_stop();

    // 5: read with no data available -> all-ones and an underrun pulse
    tx_valid = 1'b0;
    rc0 = ready_cnt; ur0 = underrun_cnt;
    exp_rd.push_back(8'hFF);
    bus_start();
    write_byte(8'h4F, ack); check("t5_addr_ack", ack, 0);
    read_byte(1'b1, d); check("t5_rd_byte", d, exp_rd.pop_front());
    check("t5_underrun_cnt", underrun_cnt - ur0, 1);
    check("t5_no_tx_ready", ready_cnt - rc0, 0);
    bus_stop();

    // 6: asynchronous reset while the target drives ACK
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(logic'((8'h4E >> i) & 8'h01));
    sda_m = 1'b1;
    for (int n = 0; n < 50 && !sda_oe; n++) @(negedge clk);
    check("t6_ack_driven", sda_oe, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_sda_oe", sda_oe, 0);
    check("t6_async_scl_oe", scl_oe, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_start();
    write_byte(8'h4E, ack); check("t6_addr_ack_after_rst", ack, 0);
    check("t6_busy", busy, 1);
    bus_stop();
    check("t6_busy_after_stop", busy, 0);
    check("end_rx_drained", exp_rx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
